bwt_mtf_encoder: RTL and testbench

Move-to-front (MTF) encoder that consumes the BWT last column produced by the sort/BWT stage. It captures the whole `STRING_LEN`-byte block when the BWT stage pulses `done`. It then streams one MTF index per symbol over a valid/ready interface, for the downstream entropy coder. A full 256-entry MTF table is held in registers; throughput is one symbol per cycle when not back-pressured.

---
 rtl/bwt_pkg.sv | 15 +
 rtl/bwt_mtf_encoder_table.sv | 37 +++
 rtl/bwt_mtf_encoder.sv | 111 +++++++++++
 tb/tb_bwt_mtf_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// Shared types for the BWT / MTF encoder pipeline.
// Symbol type, alphabet size and MTF encoder FSM states.
package bwt_pkg;

  localparam int ALPHABET_SIZE = 256;

  typedef logic [7:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    FLUSH
  } mtf_state_t;

endpackage

// File: rtl/bwt_mtf_encoder_table.sv
// 256-entry move-to-front table: combinational lookup and
// shift-to-front update; identity on rst or init.
import bwt_pkg::*;

module mtf_table (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic load,
  input  sym_t s,
  output sym_t pos
);

  sym_t tbl [ALPHABET_SIZE];

  // Descending scan so the lowest matching index wins
  always_comb begin
    pos = '0;
    for (int i = ALPHABET_SIZE - 1; i >= 0; i--) begin
      if (tbl[i] == s) pos = sym_t'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      for (int i = 0; i < ALPHABET_SIZE; i++) begin
        tbl[i] <= sym_t'(i);
      end
    end else if (load) begin
      tbl[0] <= s;
      for (int i = 1; i < ALPHABET_SIZE; i++) begin
        if (i <= int'(pos)) tbl[i] <= tbl[i-1];
      end
    end
  end

endmodule

// File: rtl/bwt_mtf_encoder.sv
// MTF encoder over a captured BWT block, valid/ready output.
// Define MTF_TABLE_KEEP_EN to keep the table across blocks.
import bwt_pkg::*;

module bwt_mtf_encoder #(
  parameter int STRING_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STRING_LEN-1:0][7:0] bwt_string,
  input  logic                       bwt_done,
  output sym_t                       mtf_data,
  output logic                       mtf_valid,
  input  logic                       mtf_ready,
  output logic                       mtf_last,
  output logic                       busy,
  output logic                       block_done,
  output logic                       overrun
);

  localparam int   IW   = $clog2(STRING_LEN);
  localparam sym_t LAST = sym_t'(STRING_LEN - 1);

  mtf_state_t state, state_nxt;

  sym_t [STRING_LEN-1:0] blk;
  sym_t                  idx;
  sym_t                  s;
  sym_t                  pos;
  logic                  capture;
  logic                  load;
  logic                  init;

  assign s    = blk[idx[IW-1:0]];
  assign busy = (state != IDLE);

`ifdef MTF_TABLE_KEEP_EN
  assign init = 1'b0;
`else
  assign init = capture;
`endif

  mtf_table u_table (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .load (load),
    .s    (s),
    .pos  (pos)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bwt_done) begin
          capture   = 1'b1;
          state_nxt = ENCODE;
        end
      end
      ENCODE: begin
        if (!mtf_valid || mtf_ready) begin
          load = 1'b1;
          if (idx == LAST) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (mtf_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtf_data   <= '0;
      mtf_valid  <= 1'b0;
      mtf_last   <= 1'b0;
      block_done <= 1'b0;
      overrun    <= 1'b0;
      idx        <= '0;
    end else begin
      block_done <= 1'b0;
      if (bwt_done && busy) overrun <= 1'b1;
      if (capture) begin
        blk <= bwt_string;
        idx <= '0;
      end
      if (load) begin
        mtf_data  <= pos;
        mtf_valid <= 1'b1;
        mtf_last  <= (idx == LAST);
        idx       <= idx + 8'd1;
      end
      // Only the last symbol is outstanding in FLUSH
      if (state == FLUSH && mtf_ready) begin
        mtf_valid  <= 1'b0;
        mtf_last   <= 1'b0;
        block_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bwt_mtf_encoder.sv
// Directed self-checking bench for bwt_mtf_encoder.
// Build with +define+MTF_TABLE_KEEP_EN for the persistent table.
module tb_bwt_mtf_encoder;
  import bwt_pkg::*;

  localparam int SL = 4;
  typedef logic [SL-1:0][7:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  blk_t bwt_string = '0;
  logic bwt_done = 1'b0;
  logic mtf_ready = 1'b0;
  sym_t mtf_data;
  logic mtf_valid;
  logic mtf_last;
  logic busy;
  logic block_done;
  logic overrun;

  int passes = 0;
  int checks = 0;
  int k;
  blk_t ex;

  always #5 clk = ~clk;

  bwt_mtf_encoder #(.STRING_LEN(SL)) dut (
    .clk        (clk),
    .rst        (rst),
    .bwt_string (bwt_string),
    .bwt_done   (bwt_done),
    .mtf_data   (mtf_data),
    .mtf_valid  (mtf_valid),
    .mtf_ready  (mtf_ready),
    .mtf_last   (mtf_last),
    .busy       (busy),
    .block_done (block_done),
    .overrun    (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic blk_t pk(input logic [7:0] a0,
                              input logic [7:0] a1,
                              input logic [7:0] a2,
                              input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bwt_done = 1'b0;
    mtf_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_blk(input string tag,
                         input blk_t b,
                         input blk_t e);
    bwt_string = b;
    bwt_done = 1'b1;
    mtf_ready = 1'b1;
    step();
    bwt_done = 1'b0;
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".val1"}, mtf_valid, 0);
    for (int n = 0; n < SL; n++) begin
      step();
      check($sformatf("%s.data%0d", tag, n), mtf_data, e[n]);
      check($sformatf("%s.valid%0d", tag, n), mtf_valid, 1);
      check($sformatf("%s.last%0d", tag, n), mtf_last,
            32'(n == SL - 1));
      check($sformatf("%s.bd%0d", tag, n), block_done, 0);
    end
    step();
    check({tag, ".bdone"}, block_done, 1);
    check({tag, ".vdone"}, mtf_valid, 0);
    check({tag, ".busy0"}, busy, 0);
  endtask

  initial begin
    do_reset();
    check("rst.data", mtf_data, 0);
    check("rst.valid", mtf_valid, 0);
    check("rst.last", mtf_last, 0);
    check("rst.busy", busy, 0);
    check("rst.bdone", block_done, 0);
    check("rst.ovr", overrun, 0);

    run_blk("b1", pk(8'h61, 8'h61, 8'h62, 8'h61),
            pk(8'h61, 8'h00, 8'h62, 8'h01));

    do_reset();
    run_blk("b2", pk(8'h00, 8'hFF, 8'h00, 8'hFF),
            pk(8'h00, 8'hFF, 8'h01, 8'h01));

    // ready toggling
    do_reset();
    ex = pk(8'h61, 8'h00, 8'h62, 8'h01);
    bwt_string = pk(8'h61, 8'h61, 8'h62, 8'h61);
    bwt_done = 1'b1;
    mtf_ready = 1'b1;
    step();
    bwt_done = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < SL; c++) begin
      mtf_ready = (c % 2 == 1);
      if (mtf_valid) begin
        check($sformatf("tg.data%0d", k), mtf_data, ex[k]);
        check($sformatf("tg.last%0d", k), mtf_last,
              32'(k == SL - 1));
        if (mtf_ready) k++;
      end
      check("tg.bd_early", block_done, 0);
      step();
    end
    check("tg.count", k, SL);
    check("tg.bdone", block_done, 1);
    check("tg.busy0", busy, 0);
    mtf_ready = 1'b1;

    // overrun during a block
    do_reset();
    bwt_string = pk(8'h61, 8'h61, 8'h62, 8'h61);
    bwt_done = 1'b1;
    mtf_ready = 1'b1;
    step();
    bwt_done = 1'b0;
    check("ov.ovr0", overrun, 0);
    step();
    check("ov.d0", mtf_data, 8'h61);
    step();
    check("ov.d1", mtf_data, 8'h00);
    bwt_string = pk(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    bwt_done = 1'b1;
    step();
    bwt_done = 1'b0;
    check("ov.ovr1", overrun, 1);
    check("ov.d2", mtf_data, 8'h62);
    step();
    check("ov.d3", mtf_data, 8'h01);
    check("ov.last", mtf_last, 1);
    check("ov.busy", busy, 1);
    step();
    check("ov.bdone", block_done, 1);
    check("ov.busy0", busy, 0);
    check("ov.ovr2", overrun, 1);
    step();
    check("ov.noblk", mtf_valid, 0);
    check("ov.idle", busy, 0);
    check("ov.ovr3", overrun, 1);

    // reset mid-stream
    bwt_string = pk(8'h61, 8'h61, 8'h62, 8'h61);
    bwt_done = 1'b1;
    step();
    bwt_done = 1'b0;
    step();
    step();
    step();
    check("mr.d2", mtf_data, 8'h62);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr.data", mtf_data, 0);
    check("mr.valid", mtf_valid, 0);
    check("mr.last", mtf_last, 0);
    check("mr.busy", busy, 0);
    check("mr.bdone", block_done, 0);
    check("mr.ovr", overrun, 0);
    run_blk("mr", pk(8'h62, 8'h62, 8'h62, 8'h62),
            pk(8'h62, 8'h00, 8'h00, 8'h00));

    // back-to-back blocks
    do_reset();
    run_blk("bb1", pk(8'h61, 8'h61, 8'h61, 8'h61),
            pk(8'h61, 8'h00, 8'h00, 8'h00));
`ifdef MTF_TABLE_KEEP_EN
    run_blk("bb2", pk(8'h61, 8'h61, 8'h61, 8'h61),
            pk(8'h00, 8'h00, 8'h00, 8'h00));
`else
    run_blk("bb2", pk(8'h61, 8'h61, 8'h61, 8'h61),
            pk(8'h61, 8'h00, 8'h00, 8'h00));
`endif
    check("bb.ovr", overrun, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
